lt100_bus_master: RTL and testbench

LT100_BUS_MASTER -- requirements
Module: lt100_bus_master

---
 rtl/lt100_bus_pkg.sv | 21 ++
 rtl/lt100_bus_master_if.sv | 40 ++++
 rtl/lt100_timeout_ctr.sv | 38 +++
 rtl/lt100_bus_master.sv | 144 ++++++++++++++
 tb/tb_lt100_bus_master.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lt100_bus_pkg.sv
// Shared types and constants for the LT100 bus master: FSM state encoding,
// response codes and the timeout counter width helper.
package lt100_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_BUS_ERR = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;
  localparam logic [1:0] RSP_BAD_BE  = 2'b11;

  // Counter must hold 0..limit; a disabled timeout (limit 0) still gets one bit.
  function automatic int unsigned ctr_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/lt100_bus_master_if.sv
// Signal bundle for the LT100 bus master: request/response handshake plus bus side.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// rsp_valid is a one-cycle pulse with no backpressure.
interface lt100_bus_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_data;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic [1:0]              rsp_err;
  logic                    enable;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   o_data;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   i_data;
  logic                    bus_err;
  logic                    irq;
  logic                    irq_sync;
  logic                    busy;

  modport master (
    input  req_valid, req_wr, req_addr, req_data, req_be, ready, i_data, bus_err, irq,
    output req_ready, rsp_valid, rsp_data, rsp_err, enable, wr_en, addr, o_data, be,
           irq_sync, busy
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_data, req_be, ready, i_data, bus_err, irq,
    input  req_ready, rsp_valid, rsp_data, rsp_err, enable, wr_en, addr, o_data, be,
           irq_sync, busy
  );
endinterface

// File: rtl/lt100_timeout_ctr.sv
// Saturating cycle counter for bus timeouts; o_tc fires on the cycle whose edge
// would bring the count to LIMIT, so the timeout lands LIMIT cycles after clear.
module lt100_timeout_ctr
  import lt100_bus_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);
  localparam int unsigned W = ctr_width(LIMIT);
  localparam logic [W-1:0] C_LIMIT = W'(LIMIT);
  localparam logic [W-1:0] C_TC    = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != C_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (LIMIT == 0) begin : g_disabled
      assign o_tc = 1'b0;
    end else begin : g_enabled
      assign o_tc = i_enable && (r_cnt == C_TC);
    end
  endgenerate

endmodule

// File: rtl/lt100_bus_master.sv
// LT100 bus master: takes one request at a time, runs a single bus cycle with
// timeout, and returns a one-cycle response pulse with status and read data.
module lt100_bus_master
  import lt100_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_err,
  output logic                    enable,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [DATA_WIDTH/8-1:0] be,
  input  logic                    ready,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    bus_err,
  input  logic                    irq,
  output logic                    irq_sync,
  output logic                    busy
);
  state_t r_state, w_next;

  logic                    w_accept, w_respond, w_capture, w_tc;
  logic [1:0]              w_code;
  logic                    r_rsp_valid, r_enable, r_wr_en, r_irq_meta, r_irq_sync;
  logic [1:0]              r_rsp_err;
  logic [DATA_WIDTH-1:0]   r_rsp_data, r_o_data;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH/8-1:0] r_be;

  lt100_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_accept),
    .i_enable (r_state == ST_ISSUE),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Priority inside ISSUE: bus_err, then ready, then timeout.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_respond = 1'b0;
    w_capture = 1'b0;
    w_code    = RSP_OK;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_be[0]) begin
            w_accept = 1'b1;
            w_next   = ST_ISSUE;
          end else begin
            w_respond = 1'b1;
            w_code    = RSP_BAD_BE;
          end
        end
      end
      ST_ISSUE: begin
        if (bus_err) begin
          w_respond = 1'b1;
          w_capture = !r_wr_en;
          w_code    = RSP_BUS_ERR;
          w_next    = ST_RECOVER;
        end else if (ready) begin
          w_respond = 1'b1;
          w_capture = !r_wr_en;
          w_next    = ST_RECOVER;
        end else if (w_tc) begin
          w_respond = 1'b1;
          w_code    = RSP_TIMEOUT;
          w_next    = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (!ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= RSP_OK;
      r_rsp_data  <= '0;
      r_enable    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_o_data    <= '0;
      r_be        <= '0;
    end else begin
      r_rsp_valid <= w_respond;
      r_enable    <= (w_next == ST_ISSUE);
      if (w_respond) r_rsp_err  <= w_code;
      if (w_capture) r_rsp_data <= i_data;
      if (w_accept) begin
        r_wr_en  <= req_wr;
        r_addr   <= req_addr;
        r_o_data <= req_data;
        r_be     <= req_be;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_meta <= 1'b0;
      r_irq_sync <= 1'b0;
    end else begin
      r_irq_meta <= irq;
      r_irq_sync <= r_irq_meta;
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign enable    = r_enable;
  assign wr_en     = r_wr_en;
  assign addr      = r_addr;
  assign o_data    = r_o_data;
  assign be        = r_be;
  assign irq_sync  = r_irq_sync;

endmodule

// File: tb/tb_lt100_bus_master.sv
// Randomized bench for lt100_bus_master against a transaction-level model of
// response code, response latency and read-data retention.
module tb_lt100_bus_master;
  import lt100_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lt100_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  lt100_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (bus_if.req_valid),
    .req_ready (bus_if.req_ready),
    .req_wr    (bus_if.req_wr),
    .req_addr  (bus_if.req_addr),
    .req_data  (bus_if.req_data),
    .req_be    (bus_if.req_be),
    .rsp_valid (bus_if.rsp_valid),
    .rsp_data  (bus_if.rsp_data),
    .rsp_err   (bus_if.rsp_err),
    .enable    (bus_if.enable),
    .wr_en     (bus_if.wr_en),
    .addr      (bus_if.addr),
    .o_data    (bus_if.o_data),
    .be        (bus_if.be),
    .ready     (bus_if.ready),
    .i_data    (bus_if.i_data),
    .bus_err   (bus_if.bus_err),
    .irq       (bus_if.irq),
    .irq_sync  (bus_if.irq_sync),
    .busy      (bus_if.busy)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] m_rdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_rsp(input string tag);
    logic [DW+1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, bus_if.rsp_valid, 1'b1);
      check({tag, "_err"}, bus_if.rsp_err, e[DW+1:DW]);
      check({tag, "_data"}, bus_if.rsp_data, e[DW-1:0]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic scramble_req();
    bus_if.req_wr   = 1'($urandom_range(0, 1));
    bus_if.req_addr = $urandom;
    bus_if.req_data = $urandom;
    bus_if.req_be   = 4'($urandom_range(0, 15));
  endtask

  // delay: edge (counted from the edge that raises enable) at which the bus answers;
  // delay > TO means the bus never answers. hold: extra cycles ready stays high after.
  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b, input int delay, input logic err,
                         input logic rdy_with_err, input int hold, input logic [DW-1:0] rd);
    logic [1:0] code;
    int resp_edge;
    check("idle_req_ready", bus_if.req_ready, 1'b1);
    check("idle_busy", bus_if.busy, 1'b0);
    bus_if.req_valid = 1'b1;
    bus_if.req_wr    = wr;
    bus_if.req_addr  = a;
    bus_if.req_data  = d;
    bus_if.req_be    = b;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    scramble_req();

    if (!b[0]) begin
      exp_q.push_back({RSP_BAD_BE, m_rdata});
      check("bad_be_enable", bus_if.enable, 1'b0);
      check("bad_be_req_ready", bus_if.req_ready, 1'b1);
      check_rsp("bad_be_rsp");
      @(negedge clk);
      check("bad_be_pulse_width", bus_if.rsp_valid, 1'b0);
      check("bad_be_enable_after", bus_if.enable, 1'b0);
      check("bad_be_err_hold", bus_if.rsp_err, RSP_BAD_BE);
      return;
    end

    if (delay <= TO) begin
      code      = err ? RSP_BUS_ERR : RSP_OK;
      resp_edge = delay;
    end else begin
      code      = RSP_TIMEOUT;
      resp_edge = TO;
    end

    for (int n = 0; n < resp_edge; n++) begin
      check("issue_enable", bus_if.enable, 1'b1);
      check("issue_wr_en", bus_if.wr_en, wr);
      check("issue_addr", bus_if.addr, a);
      check("issue_o_data", bus_if.o_data, d);
      check("issue_be", bus_if.be, b);
      check("issue_rsp_valid", bus_if.rsp_valid, 1'b0);
      check("issue_busy", bus_if.busy, 1'b1);
      check("issue_req_ready", bus_if.req_ready, 1'b0);
      if (n + 1 == delay) begin
        bus_if.ready   = err ? rdy_with_err : 1'b1;
        bus_if.bus_err = err;
        bus_if.i_data  = rd;
      end else begin
        bus_if.ready   = 1'b0;
        bus_if.bus_err = 1'b0;
        bus_if.i_data  = $urandom;
      end
      bus_if.irq = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    if (!wr && code != RSP_TIMEOUT) m_rdata = rd;
    exp_q.push_back({code, m_rdata});
    check_rsp("rsp");
    check("rsp_enable_low", bus_if.enable, 1'b0);
    check("rsp_busy", bus_if.busy, 1'b1);
    bus_if.bus_err = 1'b0;
    bus_if.i_data  = $urandom;

    for (int h = 0; h < hold; h++) begin
      bus_if.ready = 1'b1;
      @(negedge clk);
      check("recover_busy", bus_if.busy, 1'b1);
      check("recover_enable", bus_if.enable, 1'b0);
      check("recover_pulse_width", bus_if.rsp_valid, 1'b0);
    end
    bus_if.ready = 1'b0;
    @(negedge clk);
    check("back_to_idle", bus_if.busy, 1'b0);
    check("idle_enable", bus_if.enable, 1'b0);
    check("idle_rsp_valid", bus_if.rsp_valid, 1'b0);
    check("rsp_err_hold", bus_if.rsp_err, code);
    check("rsp_data_hold", bus_if.rsp_data, m_rdata);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_wr    = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_data  = '0;
    bus_if.req_be    = '0;
    bus_if.ready     = 1'b0;
    bus_if.i_data    = '0;
    bus_if.bus_err   = 1'b0;
    bus_if.irq       = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_enable", bus_if.enable, 1'b0);
    check("rst_wr_en", bus_if.wr_en, 1'b0);
    check("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_irq_sync", bus_if.irq_sync, 1'b0);
    check("rst_addr", bus_if.addr, '0);
    check("rst_o_data", bus_if.o_data, '0);
    check("rst_be", bus_if.be, '0);
    check("rst_rsp_data", bus_if.rsp_data, '0);
    check("rst_rsp_err", bus_if.rsp_err, '0);
    check("rst_req_ready", bus_if.req_ready, 1'b1);
    rst_n = 1'b1;
    bus_if.irq = 1'b0;

    // read, answered 3 cycles after enable; accepted on the first edge after reset
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 1'b0, 1'b0, 1, 32'hDEAD_BEEF);
    // byte write: read data must survive
    run_txn(1'b1, 32'h2000_0000, 32'h41, 4'h1, 2, 1'b0, 1'b0, 0, 32'h1234_5678);
    // error together with ready
    run_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 2, 1'b1, 1'b1, 0, 32'hCAFE_0001);
    // bus never ready: timeout, then recover held by a late ready
    run_txn(1'b0, 32'h0000_0200, 32'h0, 4'hF, TO + 10, 1'b0, 1'b0, 2, 32'h0);
    // ready on the very timeout cycle wins
    run_txn(1'b0, 32'h0000_0300, 32'h0, 4'hF, TO, 1'b0, 1'b0, 0, 32'h5555_AAAA);
    // bus error on the timeout cycle wins
    run_txn(1'b1, 32'h0000_0304, 32'h77, 4'h3, TO, 1'b1, 1'b0, 1, 32'h0);
    // bad byte enable
    run_txn(1'b0, 32'h0000_0400, 32'h0, 4'hE, 1, 1'b0, 1'b0, 0, 32'h0);

    // irq synchronizer: two-edge latency
    bus_if.irq = 1'b0;
    repeat (2) @(negedge clk);
    bus_if.irq = 1'b1;
    @(negedge clk);
    check("irq_sync_stage1", bus_if.irq_sync, 1'b0);
    @(negedge clk);
    check("irq_sync_stage2", bus_if.irq_sync, 1'b1);
    bus_if.irq = 1'b0;
    repeat (2) @(negedge clk);
    check("irq_sync_fall", bus_if.irq_sync, 1'b0);

    // reset in the middle of a bus cycle
    bus_if.req_valid = 1'b1;
    bus_if.req_wr    = 1'b0;
    bus_if.req_addr  = 32'h0000_0500;
    bus_if.req_be    = 4'hF;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    check("mid_rst_enable_before", bus_if.enable, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_enable_async", bus_if.enable, 1'b0);
    check("mid_rst_busy", bus_if.busy, 1'b0);
    check("mid_rst_rsp_valid", bus_if.rsp_valid, 1'b0);
    @(negedge clk);
    check("mid_rst_no_rsp", bus_if.rsp_valid, 1'b0);
    rst_n = 1'b1;
    m_rdata = '0;
    exp_q.delete();
    check("mid_rst_rsp_data", bus_if.rsp_data, '0);
    run_txn(1'b0, 32'h0000_0600, 32'h0, 4'hF, 2, 1'b0, 1'b0, 0, 32'h0BAD_F00D);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(1, TO + 2), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
